// File: rtl/i8088_bus_pkg.sv
// Shared types and default AXI window bases for the 8088 bus frontend.
// Holds the FSM state enum and the default memory and I/O base addresses.
package i8088_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ISSUE,
        ACK,
        DONE,
        HOLD
    } state_t;

    localparam logic [31:0] DEF_MEM_BASE = 32'h4000_0000;
    localparam logic [31:0] DEF_IO_BASE  = 32'h4010_0000;

endpackage

// File: rtl/i8088_bus_frontend_if.sv
// Bundles the 8088 pin-side and AXI-capture-side signals of the frontend.
// master: the frontend; slave: the CPU model / capture stage environment.
interface i8088_bus_frontend_if #(
    parameter int ADDR_WIDTH = 32
);
    // CPU side
    logic                  CPU_ALE;
    logic [7:0]            CPU_AD_IN;
    logic [11:0]           CPU_A_HI;
    logic                  CPU_IO_M;
    logic                  CPU_RD_N;
    logic                  CPU_WR_N;
    logic                  CPU_READY;
    logic [7:0]            CPU_D_OUT;
    logic                  CPU_D_OE;
    // capture stage side
    logic [ADDR_WIDTH-1:0] A;
    logic [3:0]            wstrb;
    logic [31:0]           D;
    logic                  rdaddr_fetch;
    logic                  wraddr_fetch;
    logic                  wrdata_fetch;
    logic                  axi_busy;
    logic [7:0]            read_data;

    modport master (
        input  CPU_ALE, CPU_AD_IN, CPU_A_HI, CPU_IO_M,
        input  CPU_RD_N, CPU_WR_N, axi_busy, read_data,
        output CPU_READY, CPU_D_OUT, CPU_D_OE,
        output A, wstrb, D,
        output rdaddr_fetch, wraddr_fetch, wrdata_fetch
    );

    modport slave (
        output CPU_ALE, CPU_AD_IN, CPU_A_HI, CPU_IO_M,
        output CPU_RD_N, CPU_WR_N, axi_busy, read_data,
        input  CPU_READY, CPU_D_OUT, CPU_D_OE,
        input  A, wstrb, D,
        input  rdaddr_fetch, wraddr_fetch, wrdata_fetch
    );
endinterface

// File: rtl/i8088_bus_frontend_sync2.sv
// Two-flop synchronizer for a group of asynchronous input bits.
// Ports: clk, rst (sync, active high, loads RST_VAL), d (async in), q (synced).
module sync2 #(
    parameter int              WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/i8088_bus_frontend.sv
// Bridges 8088 bus cycles to level fetch requests of an AXI capture stage.
// Ports: AXI_CLK, RESET (sync, active high), bus (i8088_bus_frontend_if.master).
module i8088_bus_frontend
    import i8088_bus_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] MEM_BASE   = DEF_MEM_BASE,
    parameter logic [31:0] IO_BASE    = DEF_IO_BASE
) (
    input  logic                  AXI_CLK,
    input  logic                  RESET,
    i8088_bus_frontend_if.master  bus
);
    logic        ale_s;
    logic [7:0]  ad_s;
    logic [11:0] a_hi_s;
    logic        io_s;
    logic        rd_s;
    logic        wr_s;

    sync2 #(.WIDTH(1), .RST_VAL(1'b0)) u_sync_ale (
        .clk(AXI_CLK), .rst(RESET), .d(bus.CPU_ALE), .q(ale_s)
    );
    sync2 #(.WIDTH(8), .RST_VAL(8'h00)) u_sync_ad (
        .clk(AXI_CLK), .rst(RESET), .d(bus.CPU_AD_IN), .q(ad_s)
    );
    sync2 #(.WIDTH(12), .RST_VAL(12'h000)) u_sync_ahi (
        .clk(AXI_CLK), .rst(RESET), .d(bus.CPU_A_HI), .q(a_hi_s)
    );
    sync2 #(.WIDTH(1), .RST_VAL(1'b0)) u_sync_io (
        .clk(AXI_CLK), .rst(RESET), .d(bus.CPU_IO_M), .q(io_s)
    );
    sync2 #(.WIDTH(2), .RST_VAL(2'b11)) u_sync_strb (
        .clk(AXI_CLK), .rst(RESET),
        .d({bus.CPU_WR_N, bus.CPU_RD_N}), .q({wr_s, rd_s})
    );

    state_t                state;
    logic                  ale_prev;
    logic [20:0]           addr_d;   // {a_hi, ad, io_m} one cycle old
    logic                  is_read;
    logic                  wr_pend;
    logic                  ready;
    logic                  d_oe;
    logic [7:0]            d_out;
    logic [ADDR_WIDTH-1:0] a_reg;
    logic [3:0]            wstrb_reg;
    logic [31:0]           d_reg;
    logic                  rd_f;
    logic                  wr_f;
    logic                  ale_fall;
    logic [31:0]           next_a;

    function automatic logic [31:0] map_addr(input logic [20:0] la);
        if (la[0])
            return IO_BASE + {16'h0000, la[16:1]};
        else
            return MEM_BASE + {12'h000, la[20:1]};
    endfunction

    // The address is taken from the cycle before the fall, since AD
    // may already carry data once ALE has dropped.
    assign ale_fall = ale_prev & ~ale_s;
    assign next_a   = map_addr(addr_d);

    always_ff @(posedge AXI_CLK) begin
        if (RESET) begin
            state     <= IDLE;
            ale_prev  <= 1'b0;
            addr_d    <= '0;
            is_read   <= 1'b0;
            wr_pend   <= 1'b0;
            ready     <= 1'b1;
            d_oe      <= 1'b0;
            d_out     <= 8'h00;
            a_reg     <= '0;
            wstrb_reg <= 4'h0;
            d_reg     <= 32'h0;
            rd_f      <= 1'b0;
            wr_f      <= 1'b0;
        end else begin
            ale_prev <= ale_s;
            addr_d   <= {a_hi_s, ad_s, io_s};
            unique case (state)
                IDLE: begin
                    if (ale_fall) begin
                        a_reg     <= next_a[ADDR_WIDTH-1:0];
                        wstrb_reg <= 4'b0001 << next_a[1:0];
                        wr_pend   <= 1'b0;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    ready <= 1'b0;
                    if (ale_fall) begin
                        a_reg     <= next_a[ADDR_WIDTH-1:0];
                        wstrb_reg <= 4'b0001 << next_a[1:0];
                        wr_pend   <= 1'b0;
                    end else if (!rd_s) begin
                        is_read <= 1'b1;
                        state   <= ISSUE;
                    end else if (wr_pend) begin
                        d_reg   <= {4{ad_s}};
                        is_read <= 1'b0;
                        state   <= ISSUE;
                    end else if (!wr_s) begin
                        // let write data settle one more cycle
                        wr_pend <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (!bus.axi_busy) begin
                        rd_f  <= is_read;
                        wr_f  <= ~is_read;
                        state <= ACK;
                    end
                end
                ACK: begin
                    if (bus.axi_busy) begin
                        rd_f  <= 1'b0;
                        wr_f  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.axi_busy) begin
                        if (is_read)
                            d_out <= bus.read_data;
                        ready <= 1'b1;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    d_oe <= is_read & ~rd_s;
                    if (rd_s && wr_s) begin
                        d_oe  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.CPU_READY    = ready;
    assign bus.CPU_D_OE     = d_oe;
    assign bus.CPU_D_OUT    = d_out;
    assign bus.A            = a_reg;
    assign bus.wstrb        = wstrb_reg;
    assign bus.D            = d_reg;
    assign bus.rdaddr_fetch = rd_f;
    assign bus.wraddr_fetch = wr_f;
    assign bus.wrdata_fetch = wr_f;
endmodule

// File: tb/tb_i8088_bus_frontend.sv
// Directed self-checking bench for i8088_bus_frontend.
// Drives 8088 bus cycles and a hand-played capture stage; checks outputs.
module tb_i8088_bus_frontend;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   rd_rises = 0;
    int   oe_cnt   = 0;
    logic rd_prev  = 1'b0;
    int   base;
    int   early;

    i8088_bus_frontend_if #(.ADDR_WIDTH(32)) bus ();

    i8088_bus_frontend #(
        .ADDR_WIDTH(32),
        .MEM_BASE(32'h4000_0000),
        .IO_BASE(32'h4010_0000)
    ) dut (
        .AXI_CLK(clk),
        .RESET(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rdaddr_fetch && !rd_prev)
            rd_rises <= rd_rises + 1;
        if (bus.CPU_D_OE)
            oe_cnt <= oe_cnt + 1;
        rd_prev <= bus.rdaddr_fetch;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // sel: 0 rdaddr_fetch, 1 wraddr_fetch, 2 CPU_READY
    task automatic wait_for(input string tag, input int sel,
                            input logic val, input int lim);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < lim && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0: hit = (bus.rdaddr_fetch === val);
                1: hit = (bus.wraddr_fetch === val);
                default: hit = (bus.CPU_READY === val);
            endcase
        end
        checks++;
        assert (hit === 1'b1) else begin
            failures++;
            $error("FAIL %s observed=timeout expected=%b", tag, val);
        end
    endtask

    task automatic addr_phase(input logic [19:0] a, input logic io);
        bus.CPU_ALE   = 1'b1;
        bus.CPU_AD_IN = a[7:0];
        bus.CPU_A_HI  = a[19:8];
        bus.CPU_IO_M  = io;
        cyc(4);
        bus.CPU_ALE   = 1'b0;
        bus.CPU_AD_IN = 8'hFF;
        cyc(6);
    endtask

    initial begin
        rst              = 1'b1;
        bus.CPU_ALE      = 1'b0;
        bus.CPU_AD_IN    = 8'h00;
        bus.CPU_A_HI     = 12'h000;
        bus.CPU_IO_M     = 1'b0;
        bus.CPU_RD_N     = 1'b1;
        bus.CPU_WR_N     = 1'b1;
        bus.axi_busy     = 1'b0;
        bus.read_data    = 8'h00;
        cyc(3);
        chk("rst_ready", 32'(bus.CPU_READY), 32'd1);
        chk("rst_oe", 32'(bus.CPU_D_OE), 32'd0);
        chk("rst_dout", 32'(bus.CPU_D_OUT), 32'd0);
        chk("rst_fetch", 32'({bus.rdaddr_fetch, bus.wraddr_fetch,
                              bus.wrdata_fetch}), 32'd0);
        chk("rst_a", bus.A, 32'd0);
        chk("rst_d", bus.D, 32'd0);
        chk("rst_wstrb", 32'(bus.wstrb), 32'd0);
        rst = 1'b0;
        cyc(2);

        // memory write 0x12345 <- 0xA5
        addr_phase(20'h12345, 1'b0);
        chk("w1_a", bus.A, 32'h4001_2345);
        chk("w1_wstrb", 32'(bus.wstrb), 32'h2);
        chk("w1_ready_low", 32'(bus.CPU_READY), 32'd0);
        bus.CPU_AD_IN = 8'hA5;
        bus.CPU_WR_N  = 1'b0;
        wait_for("w1_wrfetch", 1, 1'b1, 20);
        chk("w1_wrdata", 32'(bus.wrdata_fetch), 32'd1);
        chk("w1_rdfetch", 32'(bus.rdaddr_fetch), 32'd0);
        chk("w1_d", bus.D, 32'hA5A5_A5A5);
        cyc(3);
        chk("w1_hold", 32'({bus.wraddr_fetch, bus.wrdata_fetch}), 32'd3);
        bus.axi_busy = 1'b1;
        cyc(2);
        chk("w1_drop", 32'({bus.wraddr_fetch, bus.wrdata_fetch}), 32'd0);
        chk("w1_ready_busy", 32'(bus.CPU_READY), 32'd0);
        bus.axi_busy = 1'b0;
        wait_for("w1_ready", 2, 1'b1, 20);
        bus.CPU_WR_N = 1'b1;
        cyc(5);
        chk("w1_oe", 32'(bus.CPU_D_OE), 32'd0);

        // I/O read of port 0x03F8 returning 0x5C
        addr_phase(20'h003F8, 1'b1);
        chk("r1_a", bus.A, 32'h4010_03F8);
        bus.read_data = 8'h5C;
        bus.CPU_RD_N  = 1'b0;
        wait_for("r1_rdfetch", 0, 1'b1, 20);
        chk("r1_wrfetch", 32'(bus.wraddr_fetch), 32'd0);
        bus.axi_busy = 1'b1;
        cyc(3);
        chk("r1_ready_low", 32'(bus.CPU_READY), 32'd0);
        bus.axi_busy = 1'b0;
        wait_for("r1_ready", 2, 1'b1, 20);
        chk("r1_dout", 32'(bus.CPU_D_OUT), 32'h5C);
        cyc(3);
        chk("r1_oe_on", 32'(bus.CPU_D_OE), 32'd1);
        bus.CPU_RD_N = 1'b1;
        cyc(4);
        chk("r1_oe_off", 32'(bus.CPU_D_OE), 32'd0);

        // read issued while the capture stage is still busy
        bus.axi_busy = 1'b1;
        addr_phase(20'h0ABCD, 1'b0);
        chk("r2_a", bus.A, 32'h4000_ABCD);
        base          = rd_rises;
        bus.read_data = 8'h11;
        bus.CPU_RD_N  = 1'b0;
        early         = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (bus.rdaddr_fetch)
                early++;
        end
        chk("r2_no_fetch_busy", 32'(early), 32'd0);
        bus.axi_busy = 1'b0;
        wait_for("r2_rdfetch", 0, 1'b1, 20);
        cyc(2);
        bus.axi_busy = 1'b1;
        cyc(3);
        bus.axi_busy = 1'b0;
        wait_for("r2_ready", 2, 1'b1, 20);
        chk("r2_dout", 32'(bus.CPU_D_OUT), 32'h11);
        bus.CPU_RD_N = 1'b1;
        cyc(5);
        chk("r2_one_pulse", 32'(rd_rises - base), 32'd1);

        // RD_N released before busy falls
        addr_phase(20'h00200, 1'b0);
        base          = oe_cnt;
        bus.read_data = 8'h77;
        bus.CPU_RD_N  = 1'b0;
        wait_for("r3_rdfetch", 0, 1'b1, 20);
        bus.CPU_RD_N = 1'b1;
        bus.axi_busy = 1'b1;
        cyc(4);
        bus.axi_busy = 1'b0;
        wait_for("r3_ready", 2, 1'b1, 20);
        cyc(5);
        chk("r3_no_oe", 32'(oe_cnt - base), 32'd0);
        addr_phase(20'h00302, 1'b1);
        chk("r3_next_a", bus.A, 32'h4010_0302);
        chk("r3_next_ready", 32'(bus.CPU_READY), 32'd0);

        // reset while in ACK with a write fetch pending
        bus.CPU_AD_IN = 8'h3C;
        bus.CPU_WR_N  = 1'b0;
        wait_for("x_wrfetch", 1, 1'b1, 20);
        rst = 1'b1;
        cyc(1);
        chk("x_fetch", 32'({bus.rdaddr_fetch, bus.wraddr_fetch,
                            bus.wrdata_fetch}), 32'd0);
        chk("x_ready", 32'(bus.CPU_READY), 32'd1);
        rst          = 1'b0;
        bus.CPU_WR_N = 1'b1;
        cyc(3);
        addr_phase(20'h00203, 1'b0);
        chk("w2_a", bus.A, 32'h4000_0203);
        chk("w2_wstrb", 32'(bus.wstrb), 32'h8);
        bus.CPU_AD_IN = 8'h7E;
        bus.CPU_WR_N  = 1'b0;
        wait_for("w2_wrfetch", 1, 1'b1, 20);
        chk("w2_d", bus.D, 32'h7E7E_7E7E);
        bus.axi_busy = 1'b1;
        cyc(2);
        chk("w2_drop", 32'({bus.wraddr_fetch, bus.wrdata_fetch}), 32'd0);
        bus.axi_busy = 1'b0;
        wait_for("w2_ready", 2, 1'b1, 20);
        bus.CPU_WR_N = 1'b1;
        cyc(4);

        // both strobes low counts as a read
        addr_phase(20'h00010, 1'b0);
        bus.read_data = 8'h99;
        bus.CPU_RD_N  = 1'b0;
        bus.CPU_WR_N  = 1'b0;
        wait_for("rw_rdfetch", 0, 1'b1, 20);
        chk("rw_wrfetch", 32'(bus.wraddr_fetch), 32'd0);
        bus.axi_busy = 1'b1;
        cyc(2);
        bus.axi_busy = 1'b0;
        wait_for("rw_ready", 2, 1'b1, 20);
        chk("rw_dout", 32'(bus.CPU_D_OUT), 32'h99);
        bus.CPU_RD_N = 1'b1;
        bus.CPU_WR_N = 1'b1;
        cyc(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
